// File: rtl/multdiv.sv
// Sequential signed multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide, one-cycle completion pulse, restartable at any time.
module multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [5:0]                r_cnt;
  logic signed [2*WIDTH-1:0] r_acc;
  logic signed [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]          r_mplier;
  logic [WIDTH-1:0]          r_rem;
  logic [WIDTH-1:0]          r_quo;
  logic [WIDTH-1:0]          r_dvsr;
  logic                      r_neg;
  logic                      r_dz;
  logic [WIDTH-1:0]          r_result;
  logic                      r_exc;

  logic                      w_start;
  logic                      w_last;
  logic signed [2*WIDTH-1:0] w_addend;
  logic [WIDTH:0]            w_rem_sh;
  logic [WIDTH:0]            w_diff;

  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic f_mul_ovf(input logic signed [2*WIDTH-1:0] p);
    return p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
  endfunction

  function automatic logic [WIDTH-1:0] f_div_res(input logic [WIDTH-1:0] q,
                                                 input logic neg);
    return neg ? -q : q;
  endfunction

  // Only a positive quotient can exceed the signed range (min / -1).
  function automatic logic f_div_ovf(input logic [WIDTH-1:0] q, input logic neg);
    return !neg && q[WIDTH-1];
  endfunction

  assign w_start  = ctrl_MULT | ctrl_DIV;
  assign w_last   = (r_cnt == 6'(WIDTH));
  // Top multiplier bit carries negative weight in two's complement.
  assign w_addend = (r_cnt == 6'(WIDTH-1)) ? -r_mcand : r_mcand;
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvsr};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = IDLE;
      MUL:  if (w_last) w_next = DONE;
      DIV:  if (r_dz || w_last) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_start) w_next = ctrl_MULT ? MUL : DIV;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start)
        r_cnt <= '0;
      else if ((r_state == MUL || r_state == DIV) && !w_last)
        r_cnt <= r_cnt + 6'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
      r_mplier <= data_operandB;
      r_rem    <= '0;
      r_quo    <= f_abs(data_operandA);
      r_dvsr   <= f_abs(data_operandB);
      r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_dz     <= (data_operandB == '0);
    end else if (r_state == MUL && !w_last) begin
      if (r_mplier[0]) r_acc <= r_acc + w_addend;
      r_mcand  <= r_mcand <<< 1;
      r_mplier <= r_mplier >> 1;
    end else if (r_state == DIV && !w_last && !r_dz) begin
      if (!w_diff[WIDTH]) begin
        r_rem <= w_diff[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_rem_sh[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || w_start) begin
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (r_state == MUL && w_last) begin
      r_result <= r_acc[WIDTH-1:0];
      r_exc    <= f_mul_ovf(r_acc);
    end else if (r_state == DIV && r_dz) begin
      r_result <= '0;
      r_exc    <= 1'b1;
    end else if (r_state == DIV && w_last) begin
      r_result <= f_div_res(r_quo, r_neg);
      r_exc    <= f_div_ovf(r_quo, r_neg);
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == DONE);

endmodule

// File: tb/tb_multdiv.sv
// Scoreboard bench for multdiv: expected results queued at each start and
// matched (value, flag, completion cycle) against every RDY pulse.
module tb_multdiv;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic        prev_rdy = 1'b0;
  logic [31:0] last_res;
  logic        last_exc;

  multdiv #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: sampled on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (data_resultRDY) check("rdy_consecutive", {63'd0, prev_rdy}, 64'd0);
    if (sb_q.size() == 0) begin
      check("spurious_rdy", {63'd0, data_resultRDY}, 64'd0);
    end else if (data_resultRDY) begin
      e = sb_q.pop_front();
      check("result", {32'd0, data_result}, {32'd0, e.res});
      check("exception", {63'd0, data_exception}, {63'd0, e.exc});
      check("rdy_cycle", 64'(cyc), 64'(e.cyc));
    end
    prev_rdy = data_resultRDY;
  end

  // Reference model of the arithmetic.
  task automatic model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic exc, output int lat);
    longint p;
    longint q;
    lat = 33;
    if (mul) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[31:0];
      exc = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
      lat = 1;
    end else begin
      q   = longint'($signed(a)) / longint'($signed(b));
      res = q[31:0];
      exc = (q > 64'sd2147483647);
    end
  endtask

  // Called on a falling edge; the next rising edge is E0. Returns one cycle later.
  task automatic start_op(input bit mul, input bit div, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er,
                          input logic ee, input int lat, input bit track);
    exp_t e;
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    if (track) begin
      e.res = er; e.exc = ee; e.cyc = cyc + 1 + lat;
      sb_q.push_back(e);
      last_res = er; last_exc = ee;
    end
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic run_model(input bit mul, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        x;
    int          l;
    model(mul, a, b, r, x, l);
    start_op(mul, !mul, a, b, r, x, l, 1'b1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("completion_timeout", 64'(sb_q.size()), 64'd0);
    repeat (3) @(negedge clock);
    check("hold_result", {32'd0, data_result}, {32'd0, last_res});
    check("hold_exception", {63'd0, data_exception}, {63'd0, last_exc});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_result"}, {32'd0, data_result}, 64'd0);
    check({tag, "_exception"}, {63'd0, data_exception}, 64'd0);
    check({tag, "_rdy"}, {63'd0, data_resultRDY}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;

    start_op(1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33, 1); wait_done();
    start_op(1, 0, 32'h00010000, 32'h00010000, 32'h0, 1'b1, 33, 1); wait_done();
    start_op(1, 0, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0, 33, 1); wait_done();
    start_op(0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 33, 1); wait_done();
    start_op(0, 1, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1); wait_done();
    start_op(0, 1, 32'd5, 32'd0, 32'd0, 1'b1, 1, 1); wait_done();
    start_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 33, 1); wait_done();
    start_op(1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 33, 1); wait_done();

    // Restart: MULT at E0 is aborted by a DIV at E10.
    start_op(1, 0, 32'd3, 32'd4, 32'd12, 1'b0, 33, 0);
    repeat (9) @(negedge clock);
    start_op(0, 1, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1);
    wait_done();

    // Simultaneous MULT and DIV: multiply wins.
    start_op(1, 1, 32'd6, 32'd3, 32'd18, 1'b0, 33, 1); wait_done();

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = (i == 5) ? 32'd0 : $urandom;
      if (i[0]) b = {{20{b[31]}}, b[11:0]};
      run_model(i[1], a, b);
      wait_done();
    end

    // Reset at E15 of a multiply.
    start_op(1, 0, 32'd5, 32'd7, 32'd35, 1'b0, 33, 0);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_zero("mid_reset");
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check_zero("after_reset");

    // Reset wins over a simultaneous start.
    reset = 1'b1; ctrl_MULT = 1'b1; data_operandA = 32'd9; data_operandB = 32'd9;
    @(negedge clock);
    reset = 1'b0; ctrl_MULT = 1'b0;
    check_zero("reset_prio");
    repeat (40) @(negedge clock);

    // Start accepted on the first edge after reset.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start_op(1, 0, 32'd2, 32'd3, 32'd6, 1'b0, 33, 1); wait_done();

    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/multdiv.md
MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high. Ports are named clock and reset.
REQ-002 The block SHALL have these ports:
  - clock  in  1  master clock; all state updates on the rising edge
  - reset  in  1  synchronous, active-high reset
  - ctrl_MULT  in  1  single-cycle start pulse for a signed multiply
  - ctrl_DIV  in  1  single-cycle start pulse for a signed divide
  - data_operandA  in  32  multiplicand or dividend; sampled only on a start edge
  - data_operandB  in  32  multiplier or divisor; sampled only on a start edge
  - data_result  out  32  product or quotient (two's complement)
  - data_exception  out  1  overflow or divide-by-zero flag
  - data_resultRDY  out  1  one-cycle completion pulse
REQ-003 The block SHALL have one parameter: WIDTH, default 32, the operand and result width; only 32 is verified.

Function
REQ-004 The block SHALL implement an FSM with states IDLE, MUL, DIV and DONE, plus a 6-bit iteration counter.
REQ-005 A "start edge" is a rising edge with ctrl_MULT=1 or ctrl_DIV=1. On a start edge the block SHALL:
  - latch both operands;
  - clear data_result to 0 and data_exception to 0;
  - load counter=0;
  - enter MUL or DIV.
REQ-006 If ctrl_MULT=1 and ctrl_DIV=1 on the same edge, MULT SHALL win.
REQ-007 A start edge in any state SHALL abort the operation in progress and restart with the new operands; an aborted operation SHALL never pulse data_resultRDY.
REQ-008 MUL SHALL perform one shift-add or radix-2 Booth step per edge on a 64-bit signed product for 32 edges, then enter DONE.
REQ-009 DIV SHALL perform restoring division on the operand magnitudes, one quotient bit per edge for 32 edges, then enter DONE.
REQ-010 Divide result sign SHALL be signA XOR signB, with truncation toward zero. The remainder is discarded.
REQ-011 Latency: a start edge is E0. data_resultRDY SHALL be 1 for exactly the one cycle following edge E33. data_result and data_exception SHALL be valid in that same cycle.
REQ-012 In DONE the FSM SHALL return to IDLE on the next edge, unless that edge is a start edge.
REQ-013 data_result and data_exception SHALL hold their values after the RDY pulse until the next start edge or reset.
REQ-014 Multiply overflow: if the 64-bit product is not the sign-extension of its low 32 bits, the block SHALL set data_exception=1. data_result SHALL be the low 32 bits.
REQ-015 Divide by zero: if data_operandB=0 at a DIV start edge, the block SHALL enter DONE directly.
  - data_result=0 and data_exception=1.
  - data_resultRDY SHALL be 1 in the cycle following E1.
REQ-016 The case 0x80000000 / 0xFFFFFFFF SHALL give data_result=0x80000000 and data_exception=1, with normal 33-edge latency.
REQ-017 The case 0x80000000 × 0xFFFFFFFF SHALL give data_result=0x80000000 and data_exception=1.
REQ-018 Operand inputs changing while busy SHALL NOT affect the result.
REQ-019 data_resultRDY SHALL never be asserted in two consecutive cycles unless separated by a new start edge.

Reset
REQ-020 On a reset edge the block SHALL enter IDLE with counter=0, data_result=0, data_exception=0 and data_resultRDY=0.
REQ-021 Reset SHALL take priority over a simultaneous start edge.
REQ-022 Reset mid-operation SHALL abandon the operation; no RDY pulse SHALL follow.
REQ-023 From the first edge after reset, the block SHALL accept a start.

Verification
REQ-024 MULT 7 × 0xFFFFFFFD (-3) -> RDY pulse after E33, result 0xFFFFFFEB, exception 0.
REQ-025 MULT 0x00010000 × 0x00010000 -> result 0x00000000, exception 1. MULT 0x7FFFFFFF × 1 -> 0x7FFFFFFF, exception 0.
REQ-026 DIV 0xFFFFFFF9 (-7) / 2 -> result 0xFFFFFFFD (-3), exception 0. DIV 100 / 7 -> 14.
REQ-027 DIV 5 / 0 -> RDY after E1, result 0, exception 1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception 1, RDY after E33.
REQ-028 Restart: MULT 3 × 4 at E0, then DIV 100 / 7 at E10 -> no RDY at E33. A single RDY follows E43 with result 14. MULT and DIV asserted together -> multiply result.
REQ-029 Reset asserted at E15 of a multiply -> all outputs 0 from E15 onward and no RDY. A new MULT 2 × 3 afterwards -> result 6.
